// File: rtl/ppc_types.sv
// Shared core types and constants; DMEM_* describe the data-memory word layout.
package ppc_types;

  localparam int unsigned DMEM_BYTE_LANES = 4;
  localparam int unsigned DMEM_WORD_BITS  = 32;

  // Expand per-lane enables to a bit mask; enable bit j gates data bits [8j+7:8j].
  function automatic logic [DMEM_WORD_BITS-1:0] lane_mask(
    input logic [DMEM_BYTE_LANES-1:0] en
  );
    logic [DMEM_WORD_BITS-1:0] m;
    m = '0;
    for (int j = 0; j < DMEM_BYTE_LANES; j++) begin
      m[8*j +: 8] = {8{en[j]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with async active-high reset; storage clears on reset so the head reads 0.
module resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     storage [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_WIDTH'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: big-endian byte-lane RAM with in-order tagged read responses.
// Define DATA_MEM_STORE_ACK_EN to also return a zero-data response for stores and no-ops.
module data_mem_responder
  import ppc_types::*;
#(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned RESP_DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      to_mem_valid,
  output logic                      to_mem_ready,
  input  logic [RS_ID_WIDTH-1:0]    to_mem_rs_id,
  input  logic [4:0]                to_mem_reg_addr,
  input  logic [31:0]               mem_address,
  input  logic [3:0]                mem_write_en,
  input  logic [31:0]               mem_write_data,
  input  logic [3:0]                mem_read_en,
  output logic                      from_mem_valid,
  input  logic                      from_mem_ready,
  output logic [RS_ID_WIDTH-1:0]    from_mem_rs_id,
  output logic [4:0]                from_mem_reg_addr,
  output logic [31:0]               mem_read_data
);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0]    rs_id;
    logic [4:0]                reg_addr;
    logic [DMEM_WORD_BITS-1:0] data;
  } resp_t;

  localparam int unsigned CNT_WIDTH = $clog2(RESP_DEPTH + 1);

  // Vectors are declared [31:0] but the bus is big-endian: spec bit k is vector bit 31-k.
  // That maps the word index to address[ADDR_WIDTH+1:2] and enable bit j to data byte j.
  logic [DMEM_WORD_BITS-1:0] ram [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]     word_idx;
  logic [DMEM_WORD_BITS-1:0] old_word;
  logic [DMEM_WORD_BITS-1:0] wr_mask;
  logic                      accept;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_WIDTH-1:0]      resp_count;
  resp_t                     push_entry;
  resp_t                     head_entry;

  assign word_idx = mem_address[ADDR_WIDTH+1:2];
  assign old_word = ram[word_idx];
  assign wr_mask  = lane_mask(mem_write_en);
  assign accept   = to_mem_valid && to_mem_ready;
  assign pop      = from_mem_valid && from_mem_ready;

`ifdef DATA_MEM_STORE_ACK_EN
  assign push = accept;
`else
  assign push = accept && (mem_read_en != 4'b0000);
`endif

  // Old word captured into the FIFO on the same edge the RAM updates: read-before-write.
  always_comb begin
    push_entry          = '0;
    push_entry.rs_id    = to_mem_rs_id;
    push_entry.reg_addr = to_mem_reg_addr;
    push_entry.data     = old_word & lane_mask(mem_read_en);
  end

  always_ff @(posedge clk) begin
    if (accept && (mem_write_en != 4'b0000)) begin
      ram[word_idx] <= (old_word & ~wr_mask) | (mem_write_data & wr_mask);
    end
  end

  resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (resp_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign to_mem_ready      = !fifo_full;
  assign from_mem_valid    = !fifo_empty;
  assign from_mem_rs_id    = head_entry.rs_id;
  assign from_mem_reg_addr = head_entry.reg_addr;
  assign mem_read_data     = head_entry.data;

  logic unused_bits;
  assign unused_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0], resp_count};

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed memory model plus expected-response queue.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned WORDS = 1024;
`ifdef DATA_MEM_STORE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        to_mem_valid = 1'b0;
  logic        to_mem_ready;
  logic [4:0]  to_mem_rs_id = '0;
  logic [4:0]  to_mem_reg_addr = '0;
  logic [31:0] mem_address = '0;
  logic [3:0]  mem_write_en = '0;
  logic [31:0] mem_write_data = '0;
  logic [3:0]  mem_read_en = '0;
  logic        from_mem_valid;
  logic        from_mem_ready = 1'b0;
  logic [4:0]  from_mem_rs_id;
  logic [4:0]  from_mem_reg_addr;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rg;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mbytes [WORDS*4];
  bit         acc;

  always #5 clk = ~clk;

  data_mem_responder #(
    .RS_ID_WIDTH (5),
    .ADDR_WIDTH  (10),
    .RESP_DEPTH  (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .to_mem_valid      (to_mem_valid),
    .to_mem_ready      (to_mem_ready),
    .to_mem_rs_id      (to_mem_rs_id),
    .to_mem_reg_addr   (to_mem_reg_addr),
    .mem_address       (mem_address),
    .mem_write_en      (mem_write_en),
    .mem_write_data    (mem_write_data),
    .mem_read_en       (mem_read_en),
    .from_mem_valid    (from_mem_valid),
    .from_mem_ready    (from_mem_ready),
    .from_mem_rs_id    (from_mem_rs_id),
    .from_mem_reg_addr (from_mem_reg_addr),
    .mem_read_data     (mem_read_data)
  );

  // One cycle of stimulus from a negedge to the next; model updated at the posedge.
  // Big-endian lanes: lane i is byte address base+i, data bits [31-8i -: 8], enable bit 3-i.
  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rg,
                       input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re, input bit fr, output bit accepted);
    bit          do_pop;
    exp_t        e;
    int unsigned base;
    to_mem_valid    = v;
    to_mem_rs_id    = rs;
    to_mem_reg_addr = rg;
    mem_address     = addr;
    mem_write_en    = we;
    mem_write_data  = wd;
    mem_read_en     = re;
    from_mem_ready  = fr;
    accepted = v && (exp_q.size() < DEPTH);
    do_pop   = (exp_q.size() != 0) && fr;
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (accepted) begin
      base = ((addr >> 2) % WORDS) * 4;
      if (re != 4'b0000 || ACK) begin
        e.rs = rs;
        e.rg = rg;
        e.data = '0;
        for (int i = 0; i < 4; i++) if (re[3-i]) e.data[31-8*i -: 8] = mbytes[base+i];
        exp_q.push_back(e);
      end
      for (int i = 0; i < 4; i++) if (we[3-i]) mbytes[base+i] = wd[31-8*i -: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bit a;
    drive(1'b0, '0, '0, '0, 4'b0000, '0, 4'b0000, 1'b1, a);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (from_mem_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0", from_mem_valid);
    end
    n_checks++;
    if (to_mem_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 1", to_mem_ready);
    end
    n_checks++;
    if ({from_mem_rs_id, from_mem_reg_addr, mem_read_data} !== 42'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rs=%h reg=%h data=%h expected all zero",
               from_mem_rs_id, from_mem_reg_addr, mem_read_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (from_mem_valid !== 1'b0 || to_mem_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: got valid=%b ready=%b expected 0/1", from_mem_valid,
               to_mem_ready);
    end
  endtask

  // Give every RAM word a known value so the model never meets X.
  task automatic init_ram();
    bit a;
    for (int w = 0; w < int'(WORDS); w++) begin
      drive(1'b1, '0, '0, 32'(w * 4), 4'b1111, $urandom, 4'b0000, 1'b1, a);
    end
    idle();
  endtask

  task automatic test_full_word();
    bit a;
    drive(1'b1, 5'd0, 5'd0, 32'h10, 4'b1111, 32'hDEADBEEF, 4'b0000, 1'b1, a);
    drive(1'b1, 5'd3, 5'd7, 32'h10, 4'b0000, 32'h0, 4'b1111, 1'b1, a);
    n_checks++;
    if (from_mem_valid !== 1'b1 || mem_read_data !== 32'hDEADBEEF ||
        from_mem_rs_id !== 5'd3 || from_mem_reg_addr !== 5'd7) begin
      n_errors++;
      $display("FAIL full_word: got v=%b data=%h rs=%0d reg=%0d expected 1/deadbeef/3/7",
               from_mem_valid, mem_read_data, from_mem_rs_id, from_mem_reg_addr);
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    bit a;
    drive(1'b1, 5'd0, 5'd0, 32'h20, 4'b1111, 32'h11223344, 4'b0000, 1'b1, a);
    drive(1'b1, 5'd0, 5'd0, 32'h20, 4'b0001, 32'h000000AB, 4'b0000, 1'b1, a);
    drive(1'b1, 5'd9, 5'd4, 32'h22, 4'b0000, 32'h0, 4'b0011, 1'b1, a);
    n_checks++;
    if (mem_read_data !== 32'h000033AB) begin
      n_errors++; $display("FAIL byte_lanes: got %h expected 000033ab", mem_read_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bit a;
    int tries;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 1), 5'(k + 10), 32'(32'h100 + 4 * k), 4'b0000, 32'h0, 4'b1111,
            1'b0, a);
      n_checks++;
      if (a != (k < 2) || to_mem_ready !== (k == 0) || from_mem_rs_id !== 5'd1 ||
          mem_read_data !== exp_q[0].data) begin
        n_errors++;
        $display("FAIL stall_%0d: got acc=%b ready=%b rs=%0d data=%h expected %b/%b/1/%h",
                 k, a, to_mem_ready, from_mem_rs_id, mem_read_data, k < 2, k == 0,
                 exp_q[0].data);
      end
    end
    tries = 0;
    a = 1'b0;
    while (!a && tries < 4) begin
      drive(1'b1, 5'd3, 5'd12, 32'h108, 4'b0000, 32'h0, 4'b1111, 1'b1, a);
      tries++;
      n_checks++;
      if (from_mem_valid !== 1'b1 || from_mem_rs_id !== exp_q[0].rs ||
          mem_read_data !== exp_q[0].data) begin
        n_errors++;
        $display("FAIL release_order: got v=%b rs=%0d data=%h expected 1/%0d/%h",
                 from_mem_valid, from_mem_rs_id, mem_read_data, exp_q[0].rs, exp_q[0].data);
      end
    end
    n_checks++;
    if (tries != 2) begin
      n_errors++; $display("FAIL third_accept: got %0d cycles expected 2", tries);
    end
    while (exp_q.size() != 0 && tries < 10) begin
      n_checks++;
      if (from_mem_rs_id !== exp_q[0].rs || mem_read_data !== exp_q[0].data) begin
        n_errors++;
        $display("FAIL drain_order: got rs=%0d data=%h expected %0d/%h", from_mem_rs_id,
                 mem_read_data, exp_q[0].rs, exp_q[0].data);
      end
      idle();
      tries++;
    end
  endtask

  task automatic test_rbw();
    bit a;
    drive(1'b1, 5'd0, 5'd0, 32'h40, 4'b1111, 32'h55555555, 4'b0000, 1'b1, a);
    drive(1'b1, 5'd5, 5'd5, 32'h40, 4'b1111, 32'hAAAAAAAA, 4'b1111, 1'b1, a);
    n_checks++;
    if (mem_read_data !== 32'h55555555) begin
      n_errors++; $display("FAIL rbw_old: got %h expected 55555555", mem_read_data);
    end
    drive(1'b1, 5'd6, 5'd6, 32'h40, 4'b0000, 32'h0, 4'b1111, 1'b1, a);
    n_checks++;
    if (mem_read_data !== 32'hAAAAAAAA) begin
      n_errors++; $display("FAIL rbw_new: got %h expected aaaaaaaa", mem_read_data);
    end
    idle();
  endtask

  task automatic test_wrap();
    bit a;
    drive(1'b1, 5'd0, 5'd0, 32'h0000_1000, 4'b1111, 32'hCAFEF00D, 4'b0000, 1'b1, a);
    drive(1'b1, 5'd2, 5'd2, 32'h0, 4'b0000, 32'h0, 4'b1111, 1'b1, a);
    n_checks++;
    if (mem_read_data !== 32'hCAFEF00D) begin
      n_errors++; $display("FAIL wrap: got %h expected cafef00d", mem_read_data);
    end
    idle();
  endtask

  task automatic test_random();
    bit   a;
    logic ev;
    for (int n = 0; n < 400; n++) begin
      ev = (exp_q.size() != 0);
      n_checks++;
      if (from_mem_valid !== ev || to_mem_ready !== (exp_q.size() < DEPTH)) begin
        n_errors++;
        $display("FAIL rand_flags: cycle %0d got v=%b r=%b expected %b/%b", n,
                 from_mem_valid, to_mem_ready, ev, exp_q.size() < DEPTH);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if ({from_mem_rs_id, from_mem_reg_addr, mem_read_data} !==
            {exp_q[0].rs, exp_q[0].rg, exp_q[0].data}) begin
          n_errors++;
          $display("FAIL rand_head: cycle %0d got rs=%0d reg=%0d data=%h expected %0d/%0d/%h",
                   n, from_mem_rs_id, from_mem_reg_addr, mem_read_data, exp_q[0].rs,
                   exp_q[0].rg, exp_q[0].data);
        end
      end
      drive($urandom_range(3) != 0, 5'($urandom), 5'($urandom), $urandom,
            4'($urandom), $urandom, 4'($urandom), $urandom_range(9) < 7, a);
    end
    while (exp_q.size() != 0) idle();
  endtask

  task automatic test_reset_midflight();
    bit a;
    drive(1'b1, 5'd0, 5'd0, 32'h80, 4'b1111, 32'h0BADF00D, 4'b0000, 1'b1, a);
    idle();
    drive(1'b1, 5'd1, 5'd1, 32'h80, 4'b0000, 32'h0, 4'b1111, 1'b0, a);
    drive(1'b1, 5'd2, 5'd2, 32'h84, 4'b0000, 32'h0, 4'b1111, 1'b0, a);
    n_checks++;
    if (from_mem_valid !== 1'b1 || to_mem_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_reset: got v=%b r=%b expected 1/0", from_mem_valid, to_mem_ready);
    end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (from_mem_valid !== 1'b0 || to_mem_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b r=%b expected 0/1", from_mem_valid, to_mem_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd4, 5'd8, 32'h88, 4'b1111, 32'h12345678, 4'b0000, 1'b0, a);
    n_checks++;
    if (from_mem_valid !== ACK || mem_read_data !== 32'h0) begin
      n_errors++;
      $display("FAIL store_ack: got v=%b data=%h expected %b/00000000", from_mem_valid,
               mem_read_data, ACK);
    end
    idle();
    n_checks++;
    if (from_mem_valid !== 1'b0) begin
      n_errors++; $display("FAIL store_ack_once: got v=%b expected 0", from_mem_valid);
    end
    drive(1'b1, 5'd7, 5'd7, 32'h80, 4'b0000, 32'h0, 4'b1111, 1'b1, a);
    n_checks++;
    if (mem_read_data !== 32'h0BADF00D) begin
      n_errors++; $display("FAIL ram_persist: got %h expected 0badf00d", mem_read_data);
    end
    idle();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    init_ram();
    test_full_word();
    test_byte_lanes();
    test_back_to_back();
    test_rbw();
    test_wrap();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the load/store unit's data-memory interface. It accepts `to_mem_*` requests and performs big-endian byte-lane writes and reads on a local 32-bit-wide RAM. Read results return in request order on the `from_mem_*` interface, tagged with the request's reservation-station ID and destination register. It sits between the load/store wrapper and the (future) data cache slot and serves as the default data memory for core bring-up and simulation.

## Interface
Parameters:
- `RS_ID_WIDTH`, default 5, reservation-station ID width; must match the load/store wrapper.
- `ADDR_WIDTH`, default 10, word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- `RESP_DEPTH`, default 2, response FIFO entries; must be at least 2; must be a power of two.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `to_mem_valid` in 1: request valid.
- `to_mem_ready` out 1: request accepted when both `to_mem_valid` and `to_mem_ready` are high.
- `to_mem_rs_id` in RS_ID_WIDTH: tag, echoed in the response.
- `to_mem_reg_addr` in 5: destination GPR, echoed in the response.
- `mem_address` in 32: byte address; bit 0 is the MSB.
- `mem_write_en` in 4: byte-lane write enables; lane i covers data bits [8i:8i+7].
- `mem_write_data` in 32: store data, already lane-aligned.
- `mem_read_en` in 4: byte-lane read enables.
- `from_mem_valid` out 1: response valid.
- `from_mem_ready` in 1: response consumed when both `from_mem_valid` and `from_mem_ready` are high.
- `from_mem_rs_id` out RS_ID_WIDTH: echoed tag.
- `from_mem_reg_addr` out 5: echoed destination register.
- `mem_read_data` out 32: lane-masked read data.

## Operation
- Word index = `mem_address[30-ADDR_WIDTH:29]`.
  - Bits 30:31 are ignored; the unit aligns and lane-selects.
  - Bits above the index are ignored, so addresses wrap modulo the RAM size.
- Write: on an accepted request, each lane with `mem_write_en[i]=1` is written. Other lanes are unchanged.
- Read: on an accepted request with `mem_read_en` != 0, one response is pushed into the FIFO.
  - Each lane with `mem_read_en[i]=1` carries the stored byte; disabled lanes read 0.
  - Read and write in the same request: the read returns the pre-write data (read-before-write).
- A request with `mem_read_en`=0 produces no response (see Configuration). A request with all enables 0 is accepted as a no-op.
- Responses leave strictly in acceptance order.
- FIFO control:
  - `count` is 0..RESP_DEPTH, with wrapping read/write pointers of log2(RESP_DEPTH) bits.
  - `to_mem_ready = (count != RESP_DEPTH)`, derived from registered state only. There is no combinational path from `from_mem_ready`.
  - Push and pop in the same cycle leave `count` unchanged and advance both pointers.
  - When full, `to_mem_ready` is low, so a push and pop in the same cycle cannot occur at full.
  - Pop when empty is impossible because `from_mem_valid = (count != 0)`.
- The response outputs always reflect the FIFO head entry. They are held stable while `from_mem_valid` is high and `from_mem_ready` is low.

## Timing
- Latency: a request accepted at clock edge N is visible with `from_mem_valid` high in the cycle after edge N. The RAM read is synchronous and written directly into the FIFO entry.
- Throughput: one request per cycle at RESP_DEPTH=2 with the consumer always ready.
- Write data is visible to any request accepted at edge N+1 or later.
- Reset values:
  - `from_mem_valid`=0.
  - `to_mem_ready`=1.
  - `from_mem_rs_id`, `from_mem_reg_addr` and `mem_read_data` = 0, because FIFO storage resets to 0.
- Reset mid-operation: `count` and the pointers clear immediately, and pending responses are discarded.
- RAM contents are not reset and are not cleared; stores completed before reset persist.

## Configuration
- `DATA_MEM_STORE_ACK_EN` defined: every accepted request with `mem_read_en`=0 also pushes a response with `mem_read_data`=0. Ordering and FIFO accounting are identical to reads. This lets the core track store completion.
- `DATA_MEM_STORE_ACK_EN` undefined: stores and no-ops produce no response.

## Structure
- `ppc_types` gains `DMEM_BYTE_LANES`=4 and `DMEM_WORD_BITS`=32.
- The response entry struct is local to the module, because it depends on RS_ID_WIDTH.
- One sub-module is natural: `resp_fifo`, a parameterized-width, RESP_DEPTH synchronous FIFO with async reset, `count`, `full` and `empty`. The RAM and lane logic stay in the top module.

## Test plan
- Write 0xDEADBEEF with `mem_write_en`=4'b1111 to address 0x10; then read with `mem_read_en`=4'b1111, rs_id=3, reg_addr=7. Expect one cycle later: `from_mem_valid`=1, data 0xDEADBEEF, rs_id 3, reg_addr 7.
- Write 0x000000AB with lanes 4'b0001 over 0x11223344, then read lanes 4'b0011. Expect 0x000033AB.
- Hold `from_mem_ready`=0 and issue 3 back-to-back reads. Expect `to_mem_ready` to drop after 2 acceptances; the outputs hold the first response. Release, and expect the responses in order with the third accepted afterwards.
- Read and write the same word in one request (old value 0x55555555, new value 0xAAAAAAAA). Expect the response 0x55555555; a following read returns 0xAAAAAAAA.
- Write to address 0x0000_1000 with ADDR_WIDTH=10. Expect a read of address 0 to return the written data (wrap-around).
- Assert `rst` while 2 responses are pending. Expect `from_mem_valid`=0 and `to_mem_ready`=1 immediately. With the macro defined, expect a store to return one response with zero data; with it undefined, expect none.
